// File: rtl/pio_button_led_pkg.sv
// rtl/pio_button_led_pkg.sv - shared constants for the button/LED PIO peripheral
// Contents: register word offsets, bus address width, INFO version byte,
//           and the debounce counter width helper.
package pio_button_led_pkg;

   localparam int ADDR_W = 3;
   localparam logic [7:0] VERSION = 8'h01;

   localparam logic [ADDR_W-1:0] REG_BTN_STATE = 3'd0;
   localparam logic [ADDR_W-1:0] REG_EDGE_CAP  = 3'd1;
   localparam logic [ADDR_W-1:0] REG_IRQ_MASK  = 3'd2;
   localparam logic [ADDR_W-1:0] REG_LED_DATA  = 3'd3;
   localparam logic [ADDR_W-1:0] REG_LED_BLINK = 3'd4;
   localparam logic [ADDR_W-1:0] REG_INFO      = 3'd5;

   // Width able to hold a count of 0..cycles.
   function automatic int deb_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/pio_debounce_chan.sv
// rtl/pio_debounce_chan.sv - synchroniser, polarity normalisation and debounce for one button
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   btn_pin    : raw asynchronous pin
//   state      : debounced level, 1 = pressed
//   press      : one-cycle pulse on an accepted press, suppressed for a
//                button that has been held since reset
module pio_debounce_chan
   import pio_button_led_pkg::*;
#(
   parameter bit BTN_ACTIVE_LOW  = 1'b1,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_pin,
   output logic state,
   output logic press
);

   localparam int CW = deb_cnt_w(DEBOUNCE_CYCLES);
   localparam logic RELEASED_PIN = BTN_ACTIVE_LOW;

   logic          sync1;
   logic          sync2;
   logic [1:0]    vld;
   logic          armed;
   logic [CW-1:0] cnt;
   logic          pressed;

   assign pressed = sync2 ^ BTN_ACTIVE_LOW;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= RELEASED_PIN;
         sync2 <= RELEASED_PIN;
         vld   <= '0;
         armed <= 1'b0;
         cnt   <= '0;
         state <= 1'b0;
         press <= 1'b0;
      end else begin
         sync1 <= btn_pin;
         sync2 <= sync1;
         // vld[1] marks that sync2 now carries a real pin sample rather than
         // its reset value, so arming only happens on a genuinely seen release.
         vld   <= {vld[0], 1'b1};
         press <= 1'b0;
         if (vld[1] && !state && !pressed)
            armed <= 1'b1;
         if (pressed == state) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= pressed;
            press <= pressed & armed;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/pio_button_led_ctrl.sv
// rtl/pio_button_led_ctrl.sv - Avalon-MM button/LED peripheral with edge capture, irq and blink
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   avs_address/read/write/writedata/readdata : register slave, read latency 1, no wait states
//   btn_in  [N_BUTTONS] : raw button pins
//   led_out [N_LEDS]    : registered LED drive, active-high
//   irq                 : registered level interrupt, |(EDGE_CAP & IRQ_MASK)
module pio_button_led_ctrl
   import pio_button_led_pkg::*;
#(
   parameter int N_BUTTONS         = 2,
   parameter int N_LEDS            = 8,
   parameter bit BTN_ACTIVE_LOW    = 1'b1,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int BLINK_HALF_PERIOD = 12500000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_W-1:0]    avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   input  logic [N_BUTTONS-1:0] btn_in,
   output logic [N_LEDS-1:0]    led_out,
   output logic                 irq
);

   localparam int BW = $clog2(BLINK_HALF_PERIOD);

   logic [N_BUTTONS-1:0] btn_state;
   logic [N_BUTTONS-1:0] press;
   logic [N_BUTTONS-1:0] edge_cap;
   logic [N_BUTTONS-1:0] irq_mask;
   logic [N_BUTTONS-1:0] w1c;
   logic [N_LEDS-1:0]    led_data;
   logic [N_LEDS-1:0]    led_blink;
   logic [BW-1:0]        blink_cnt;
   logic                 blink_phase;
   logic [31:0]          rd_mux;
   logic                 unused_wdata;

   // Upper write-data bits are legitimately ignored for narrow configurations.
   assign unused_wdata = ^avs_writedata;

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
      pio_debounce_chan #(
         .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clk     (clk),
         .reset   (reset),
         .btn_pin (btn_in[i]),
         .state   (btn_state[i]),
         .press   (press[i])
      );
   end

   assign w1c = (avs_write && avs_address == REG_EDGE_CAP) ?
                avs_writedata[N_BUTTONS-1:0] : '0;

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         REG_BTN_STATE: rd_mux = 32'(btn_state);
         REG_EDGE_CAP:  rd_mux = 32'(edge_cap);
         REG_IRQ_MASK:  rd_mux = 32'(irq_mask);
         REG_LED_DATA:  rd_mux = 32'(led_data);
         REG_LED_BLINK: rd_mux = 32'(led_blink);
         REG_INFO:      rd_mux = {8'd0, 8'(N_LEDS), 8'(N_BUTTONS), VERSION};
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         edge_cap     <= '0;
         irq_mask     <= '0;
         led_data     <= '0;
         led_blink    <= '0;
         blink_cnt    <= '0;
         blink_phase  <= 1'b0;
         led_out      <= '0;
         irq          <= 1'b0;
         avs_readdata <= '0;
      end else begin
         if (avs_write && avs_address == REG_IRQ_MASK)
            irq_mask <= avs_writedata[N_BUTTONS-1:0];
         if (avs_write && avs_address == REG_LED_DATA)
            led_data <= avs_writedata[N_LEDS-1:0];
         if (avs_write && avs_address == REG_LED_BLINK)
            led_blink <= avs_writedata[N_LEDS-1:0];

         // A press arriving with a clear of the same bit keeps the bit set.
         edge_cap <= (edge_cap & ~w1c) | press;
         irq      <= |(edge_cap & irq_mask);

         if (blink_cnt == BW'(BLINK_HALF_PERIOD - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
         led_out <= led_data & (~led_blink | {N_LEDS{blink_phase}});

         // Registers are sampled before this edge's writes land, so a
         // colliding read returns the old contents.
         if (avs_read)
            avs_readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_pio_button_led_ctrl.sv
// tb/tb_pio_button_led_ctrl.sv - directed self-checking bench for pio_button_led_ctrl
module tb_pio_button_led_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic [1:0]  btn_in;
   logic [7:0]  led_out;
   logic        irq;

   int n_cmp  = 0;
   int n_fail = 0;
   int ncyc   = 0;

   logic [31:0] rd;
   logic [31:0] exp_v;
   logic [31:0] exp_reset [8];

   pio_button_led_ctrl #(
      .N_BUTTONS         (2),
      .N_LEDS            (8),
      .BTN_ACTIVE_LOW    (1'b1),
      .DEBOUNCE_CYCLES   (4),
      .BLINK_HALF_PERIOD (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .btn_in        (btn_in),
      .led_out       (led_out),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   // Non-reset edges since the last reset; the blink phase is a pure function of it.
   always @(posedge clk) begin
      if (reset) ncyc <= 0;
      else       ncyc <= ncyc + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      step();
      avs_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      step();
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   initial begin
      exp_reset = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0008_0201, 32'h0, 32'h0};
      reset = 1'b1; btn_in = 2'b11;
      avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
      repeat (3) step();
      reset = 1'b0;

      // Reset state
      check("reset_irq", 32'(irq), 32'd0);
      check("reset_led", 32'(led_out), 32'd0);
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), rd);
         check($sformatf("reset_rd_%0d", a), rd, exp_reset[a]);
      end

      bus_write(3'd2, 32'h3);

      // Short glitch on button 1 is rejected
      btn_in[1] = 1'b0;
      repeat (3) step();
      btn_in[1] = 1'b1;
      repeat (10) begin
         step();
         check("glitch_irq", 32'(irq), 32'd0);
      end
      bus_read(3'd0, rd); check("glitch_state", rd, 32'd0);
      bus_read(3'd1, rd); check("glitch_edge", rd, 32'd0);

      // Press latency on button 0: state after edge 6, readable at edge 7, irq at edge 8
      btn_in[0] = 1'b0;
      avs_address = 3'd0;
      avs_read = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         check($sformatf("press_state_k%0d", k), avs_readdata, (k >= 7) ? 32'd1 : 32'd0);
         check($sformatf("press_irq_k%0d", k), 32'(irq), (k >= 8) ? 32'd1 : 32'd0);
      end
      avs_read = 1'b0;
      bus_read(3'd1, rd); check("press_edge", rd, 32'd1);

      // Release does not add or remove captured edges; then clear
      btn_in[0] = 1'b1;
      repeat (10) step();
      bus_read(3'd1, rd); check("release_edge", rd, 32'd1);
      bus_write(3'd1, 32'h1);
      check("clr1_irq_old", 32'(irq), 32'd1);
      bus_read(3'd1, rd); check("clr1_edge", rd, 32'd0);
      check("clr1_irq", 32'(irq), 32'd0);

      // Clear in the same cycle as a new capture: the set wins
      btn_in[0] = 1'b0;
      repeat (6) step();
      bus_write(3'd1, 32'h1);
      check("coll_irq_e7", 32'(irq), 32'd0);
      bus_read(3'd1, rd); check("coll_edge", rd, 32'd1);
      check("coll_irq_e8", 32'(irq), 32'd1);

      // Later clear with the button still held and no new press
      repeat (4) step();
      bus_write(3'd1, 32'h1);
      check("clr2_irq_old", 32'(irq), 32'd1);
      bus_read(3'd1, rd); check("clr2_edge", rd, 32'd0);
      check("clr2_irq", 32'(irq), 32'd0);
      btn_in[0] = 1'b1;
      repeat (10) step();

      // Blink: upper nibble steady, lower nibble follows the phase
      bus_write(3'd3, 32'hA5);
      bus_write(3'd4, 32'h0F);
      bus_read(3'd3, rd); check("led_data_rd", rd, 32'hA5);
      for (int j = 0; j < 12; j++) begin
         step();
         exp_v = ((((ncyc - 1) / 4) % 2) != 0) ? 32'hA5 : 32'hA0;
         check($sformatf("blink_%0d", j), 32'(led_out), exp_v);
      end

      // Get irq high on button 1, then reset during a button 0 debounce
      btn_in[1] = 1'b0;
      repeat (10) step();
      check("pre_rst_irq", 32'(irq), 32'd1);
      btn_in[1] = 1'b1;
      repeat (10) step();
      btn_in[0] = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      check("rst_led", 32'(led_out), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", avs_readdata, 32'd0);
      reset = 1'b0;
      bus_read(3'd0, rd); check("rst_state", rd, 32'd0);
      bus_write(3'd2, 32'h3);

      // Held through reset: debounced state follows but no edge is captured
      repeat (10) step();
      bus_read(3'd0, rd); check("held_state", rd, 32'd1);
      bus_read(3'd1, rd); check("held_edge", rd, 32'd0);
      check("held_irq", 32'(irq), 32'd0);
      btn_in[0] = 1'b1;
      repeat (10) step();
      bus_read(3'd1, rd); check("rel_edge", rd, 32'd0);
      btn_in[0] = 1'b0;
      repeat (10) step();
      bus_read(3'd1, rd); check("repress_edge", rd, 32'd1);
      check("repress_irq", 32'(irq), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
